// File: rtl/id_ex_pipe_reg.sv
// Purpose: parametrised ID->EX pipeline register carrying IR, PC+4, operand lanes and flags.
// Latency: one cycle from the _D inputs to the _E outputs; every output comes straight from a flop.
// Backpressure: Stall holds the whole stage; Flush inserts a bubble and wins over Stall.
//
// Ports:
//   Clk, Reset            clock and synchronous active-high reset
//   Stall, Flush          hold / bubble controls (Reset > Flush > Stall > load)
//   Valid_D, IR_D, PC4_D, Lanes_D, Flags_D   decode-side payload
//   Valid_E, IR_E, PC4_E, Lanes_E, Flags_E   execute-side registered payload
//   Stall_Run             consecutive stall cycles, saturating at 255
//   Stall_Timeout         registered (Stall_Run >= STALL_LIMIT)
//   Bubble_Cnt, Stall_Cnt optional performance counters, present only when
//                         ID_EX_PERF_CNT_EN is defined
module id_ex_pipe_reg #(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        NUM_LANES   = 3,
  parameter int unsigned        FLAG_W      = 1,
  parameter logic [DATA_W-1:0]  PC_RESET    = 32'h0000_3000,
  parameter logic [DATA_W-1:0]  NOP_IR      = '0,
  parameter int unsigned        STALL_LIMIT = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Stall,
  input  logic                          Flush,
  input  logic                          Valid_D,
  input  logic [DATA_W-1:0]             IR_D,
  input  logic [DATA_W-1:0]             PC4_D,
  input  logic [NUM_LANES*DATA_W-1:0]   Lanes_D,
  input  logic [FLAG_W-1:0]             Flags_D,
  output logic                          Valid_E,
  output logic [DATA_W-1:0]             IR_E,
  output logic [DATA_W-1:0]             PC4_E,
  output logic [NUM_LANES*DATA_W-1:0]   Lanes_E,
  output logic [FLAG_W-1:0]             Flags_E,
  output logic [7:0]                    Stall_Run,
  output logic                          Stall_Timeout
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]                   Bubble_Cnt,
  output logic [31:0]                   Stall_Cnt
`endif
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  // Declaration initialisers make the power-up state match the reset state.
  logic                        valid_q = 1'b0;
  logic [DATA_W-1:0]           ir_q    = NOP_IR;
  logic [DATA_W-1:0]           pc4_q   = PC_RESET;
  logic [NUM_LANES*DATA_W-1:0] lanes_q = '0;
  logic [FLAG_W-1:0]           flags_q = '0;
  logic [7:0]                  run_q   = 8'd0;
  logic                        tmo_q   = 1'b0;
  logic [7:0]                  run_nxt;

  // Next stall-run value ignoring Reset; a flush or load clears it, a plain
  // stall counts up and sticks at 255 so the timeout can never fall mid-stall.
  always_comb begin
    run_nxt = 8'd0;
    if (!Flush && Stall) begin
      run_nxt = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      ir_q    <= NOP_IR;
      pc4_q   <= PC_RESET;
      lanes_q <= '0;
      flags_q <= '0;
      run_q   <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      if (Flush) begin
        // Bubble keeps its PC so a debugger can still place it in the stream.
        valid_q <= 1'b0;
        ir_q    <= NOP_IR;
        pc4_q   <= PC4_D;
        lanes_q <= '0;
        flags_q <= '0;
      end else if (!Stall) begin
        valid_q <= Valid_D;
        ir_q    <= IR_D;
        pc4_q   <= PC4_D;
        lanes_q <= Lanes_D;
        flags_q <= Flags_D;
      end
      run_q <= run_nxt;
      tmo_q <= (run_nxt >= LIMIT);
    end
  end

  assign Valid_E       = valid_q;
  assign IR_E          = ir_q;
  assign PC4_E         = pc4_q;
  assign Lanes_E       = lanes_q;
  assign Flags_E       = flags_q;
  assign Stall_Run     = run_q;
  assign Stall_Timeout = tmo_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_q = 32'd0;
  logic [31:0] stall_q  = 32'd0;

  // Both counters wrap freely; a stall overridden by a flush counts as a bubble only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubble_q <= 32'd0;
      stall_q  <= 32'd0;
    end else begin
      if (Flush) begin
        bubble_q <= bubble_q + 32'd1;
      end
      if (Stall && !Flush) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign Bubble_Cnt = bubble_q;
  assign Stall_Cnt  = stall_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
`timescale 1ns/1ps
module tb_id_ex_pipe_reg;
  localparam int DW = 32;
  localparam int NL = 3;
  localparam int FW = 1;
  localparam int OW = 1 + DW + DW + NL*DW + FW + 8 + 1;
  localparam int SW = 1 + DW + DW + DW + 1 + 8 + 1;
  typedef logic [OW-1:0] obs_t;
  typedef logic [SW-1:0] sobs_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic            Reset = 1'b0, Stall = 1'b0, Flush = 1'b0, Valid_D = 1'b0;
  logic [DW-1:0]   IR_D = '0, PC4_D = '0;
  logic [NL*DW-1:0] Lanes_D = '0;
  logic [FW-1:0]   Flags_D = '0;
  logic            Valid_E;
  logic [DW-1:0]   IR_E, PC4_E;
  logic [NL*DW-1:0] Lanes_E;
  logic [FW-1:0]   Flags_E;
  logic [7:0]      Stall_Run;
  logic            Stall_Timeout;

  logic            s_Stall = 1'b0, s_Flush = 1'b0, s_Valid_D = 1'b0;
  logic [DW-1:0]   s_IR_D = '0, s_PC4_D = '0, s_Lanes_D = '0;
  logic [0:0]      s_Flags_D = '0;
  logic            s_Valid_E;
  logic [DW-1:0]   s_IR_E, s_PC4_E, s_Lanes_E;
  logic [0:0]      s_Flags_E;
  logic [7:0]      s_Stall_Run;
  logic            s_Stall_Timeout;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] Bubble_Cnt, Stall_Cnt, s_Bubble_Cnt, s_Stall_Cnt;
`endif

  id_ex_pipe_reg #(.DATA_W(DW), .NUM_LANES(NL), .FLAG_W(FW), .STALL_LIMIT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_D(Valid_D),
    .IR_D(IR_D), .PC4_D(PC4_D), .Lanes_D(Lanes_D), .Flags_D(Flags_D),
    .Valid_E(Valid_E), .IR_E(IR_E), .PC4_E(PC4_E), .Lanes_E(Lanes_E), .Flags_E(Flags_E),
    .Stall_Run(Stall_Run), .Stall_Timeout(Stall_Timeout)
`ifdef ID_EX_PERF_CNT_EN
    , .Bubble_Cnt(Bubble_Cnt), .Stall_Cnt(Stall_Cnt)
`endif
  );

  id_ex_pipe_reg #(.DATA_W(DW), .NUM_LANES(1), .FLAG_W(1)) u_small (
    .Clk(Clk), .Reset(Reset), .Stall(s_Stall), .Flush(s_Flush), .Valid_D(s_Valid_D),
    .IR_D(s_IR_D), .PC4_D(s_PC4_D), .Lanes_D(s_Lanes_D), .Flags_D(s_Flags_D),
    .Valid_E(s_Valid_E), .IR_E(s_IR_E), .PC4_E(s_PC4_E), .Lanes_E(s_Lanes_E), .Flags_E(s_Flags_E),
    .Stall_Run(s_Stall_Run), .Stall_Timeout(s_Stall_Timeout)
`ifdef ID_EX_PERF_CNT_EN
    , .Bubble_Cnt(s_Bubble_Cnt), .Stall_Cnt(s_Stall_Cnt)
`endif
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  obs_t  sb[$];
  sobs_t sb_s[$];
  obs_t  got, exp_v;
  sobs_t s_got, s_exp;

  function automatic obs_t mk(input logic v, input logic [DW-1:0] ir, input logic [DW-1:0] pc,
                              input logic [NL*DW-1:0] ln, input logic [FW-1:0] fl,
                              input logic [7:0] run, input logic tmo);
    return {v, ir, pc, ln, fl, run, tmo};
  endfunction

  function automatic obs_t observe();
    return {Valid_E, IR_E, PC4_E, Lanes_E, Flags_E, Stall_Run, Stall_Timeout};
  endfunction

  function automatic sobs_t s_observe();
    return {s_Valid_E, s_IR_E, s_PC4_E, s_Lanes_E, s_Flags_E, s_Stall_Run, s_Stall_Timeout};
  endfunction

  function automatic logic [NL*DW-1:0] rnd_lanes();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Values held from the last load, reused as expectations across tasks.
  logic [DW-1:0]    h_ir, h_pc;
  logic [NL*DW-1:0] h_ln;
  logic [FW-1:0]    h_fl;
  logic             h_v;

  task automatic test_reset();
    Reset = 1'b1; Stall = 1'b1; Flush = 1'b1; Valid_D = 1'b1;
    IR_D = 32'hDEAD_BEEF; PC4_D = 32'h0000_1234; Lanes_D = '1; Flags_D = '1;
    #1;
    sb.push_back(mk(1'b0, 32'h0, 32'h0000_3000, '0, '0, 8'd0, 1'b0));
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL power_up: got %h exp %h", got, exp_v); end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1'b0, 32'h0, 32'h0000_3000, '0, '0, 8'd0, 1'b0));
      @(posedge Clk); #1;
      got = observe(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL reset_edge%0d: got %h exp %h", i, got, exp_v); end
    end
    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
  endtask

  task automatic test_load();
    Valid_D = 1'b1; IR_D = 32'h8C22_0004; PC4_D = 32'h0000_3004;
    Lanes_D = {32'h4, 32'h22, 32'h11}; Flags_D = 1'b1;
    #2;
    sb.push_back(mk(1'b0, 32'h0, 32'h0000_3000, '0, '0, 8'd0, 1'b0));
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL load_no_comb_path: got %h exp %h", got, exp_v); end
    h_v = 1'b1; h_ir = 32'h8C22_0004; h_pc = 32'h0000_3004; h_ln = {32'h4, 32'h22, 32'h11}; h_fl = 1'b1;
    sb.push_back(mk(h_v, h_ir, h_pc, h_ln, h_fl, 8'd0, 1'b0));
    @(posedge Clk); #1;
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL load: got %h exp %h", got, exp_v); end
  endtask

  task automatic test_stall();
    Stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      IR_D = $urandom; PC4_D = $urandom; Lanes_D = rnd_lanes(); Flags_D = 1'($urandom); Valid_D = 1'b0;
      sb.push_back(mk(h_v, h_ir, h_pc, h_ln, h_fl, 8'(i), 1'b0));
      @(posedge Clk); #1;
      got = observe(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL stall_hold%0d: got %h exp %h", i, got, exp_v); end
    end
    Stall = 1'b0; Valid_D = 1'b1; IR_D = 32'h0123_4567; PC4_D = 32'h0000_3008;
    Lanes_D = {32'hA, 32'hB, 32'hC}; Flags_D = 1'b0;
    h_v = 1'b1; h_ir = 32'h0123_4567; h_pc = 32'h0000_3008; h_ln = {32'hA, 32'hB, 32'hC}; h_fl = 1'b0;
    sb.push_back(mk(h_v, h_ir, h_pc, h_ln, h_fl, 8'd0, 1'b0));
    @(posedge Clk); #1;
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL stall_release: got %h exp %h", got, exp_v); end
  endtask

  task automatic test_flush();
    Stall = 1'b1;
    sb.push_back(mk(h_v, h_ir, h_pc, h_ln, h_fl, 8'd1, 1'b0));
    @(posedge Clk); #1;
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL pre_flush_stall: got %h exp %h", got, exp_v); end
    Flush = 1'b1; PC4_D = 32'h0000_3010; IR_D = 32'h1234_5678; Valid_D = 1'b1;
    Lanes_D = rnd_lanes(); Flags_D = 1'b1;
    sb.push_back(mk(1'b0, 32'h0, 32'h0000_3010, '0, '0, 8'd0, 1'b0));
    @(posedge Clk); #1;
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL flush_over_stall: got %h exp %h", got, exp_v); end
    // A stall right after a bubble must keep Valid_E low.
    Flush = 1'b0; Stall = 1'b1; PC4_D = 32'h0000_3014;
    sb.push_back(mk(1'b0, 32'h0, 32'h0000_3010, '0, '0, 8'd1, 1'b0));
    @(posedge Clk); #1;
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL stall_on_bubble: got %h exp %h", got, exp_v); end
    Reset = 1'b1; Flush = 1'b1;
    sb.push_back(mk(1'b0, 32'h0, 32'h0000_3000, '0, '0, 8'd0, 1'b0));
    @(posedge Clk); #1;
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_mid_stall_flush: got %h exp %h", got, exp_v); end
    Reset = 1'b0; Flush = 1'b0; Stall = 1'b0;
  endtask

  task automatic test_timeout();
    logic [7:0] run;
    Valid_D = 1'b1; IR_D = 32'h2001_0005; PC4_D = 32'h0000_3020; Lanes_D = {32'h3, 32'h2, 32'h1}; Flags_D = 1'b0;
    h_v = 1'b1; h_ir = 32'h2001_0005; h_pc = 32'h0000_3020; h_ln = {32'h3, 32'h2, 32'h1}; h_fl = 1'b0;
    sb.push_back(mk(h_v, h_ir, h_pc, h_ln, h_fl, 8'd0, 1'b0));
    @(posedge Clk); #1;
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL timeout_preload: got %h exp %h", got, exp_v); end
    Stall = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      IR_D = $urandom; PC4_D = $urandom; Lanes_D = rnd_lanes(); Flags_D = 1'($urandom);
      run = (i > 255) ? 8'd255 : 8'(i);
      sb.push_back(mk(h_v, h_ir, h_pc, h_ln, h_fl, run, (run >= 8'd4)));
      @(posedge Clk); #1;
      got = observe(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL timeout_stall%0d: got %h exp %h", i, got, exp_v); end
    end
    Stall = 1'b0; Valid_D = 1'b0; IR_D = 32'h0000_0BAD; PC4_D = 32'h0000_3024; Lanes_D = '0; Flags_D = 1'b1;
    sb.push_back(mk(1'b0, 32'h0000_0BAD, 32'h0000_3024, '0, 1'b1, 8'd0, 1'b0));
    @(posedge Clk); #1;
    got = observe(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL timeout_clear: got %h exp %h", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      Valid_D = 1'(i); IR_D = $urandom; PC4_D = $urandom; Lanes_D = rnd_lanes(); Flags_D = 1'($urandom);
      sb.push_back(mk(Valid_D, IR_D, PC4_D, Lanes_D, Flags_D, 8'd0, 1'b0));
      @(posedge Clk); #1;
      got = observe(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL back_to_back%0d: got %h exp %h", i, got, exp_v); end
    end
  endtask

  task automatic test_single_lane();
    s_Valid_D = 1'b1; s_IR_D = 32'h0000_00A5; s_PC4_D = 32'h0000_4000; s_Lanes_D = 32'h77; s_Flags_D = 1'b1;
    sb_s.push_back({1'b1, 32'h0000_00A5, 32'h0000_4000, 32'h77, 1'b1, 8'd0, 1'b0});
    @(posedge Clk); #1;
    s_got = s_observe(); s_exp = sb_s.pop_front(); n_chk++;
    if (s_got !== s_exp) begin n_fail++; $display("FAIL single_lane_load: got %h exp %h", s_got, s_exp); end
    s_Stall = 1'b1; s_IR_D = 32'h0000_0001; s_Lanes_D = 32'h99;
    sb_s.push_back({1'b1, 32'h0000_00A5, 32'h0000_4000, 32'h77, 1'b1, 8'd1, 1'b0});
    @(posedge Clk); #1;
    s_got = s_observe(); s_exp = sb_s.pop_front(); n_chk++;
    if (s_got !== s_exp) begin n_fail++; $display("FAIL single_lane_stall: got %h exp %h", s_got, s_exp); end
    s_Flush = 1'b1; s_PC4_D = 32'h0000_4004;
    sb_s.push_back({1'b0, 32'h0, 32'h0000_4004, 32'h0, 1'b0, 8'd0, 1'b0});
    @(posedge Clk); #1;
    s_got = s_observe(); s_exp = sb_s.pop_front(); n_chk++;
    if (s_got !== s_exp) begin n_fail++; $display("FAIL single_lane_flush: got %h exp %h", s_got, s_exp); end
    s_Flush = 1'b0; s_Stall = 1'b0;
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf_cnt();
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    @(posedge Clk); #1;
    n_chk++;
    if (Bubble_Cnt !== 32'd0 || Stall_Cnt !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d exp 0/0", Bubble_Cnt, Stall_Cnt);
    end
    Reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      Flush = (i < 5);
      Stall = (i >= 4);
      @(posedge Clk); #1;
    end
    Flush = 1'b0; Stall = 1'b0;
    n_chk++;
    if (Bubble_Cnt !== 32'd5) begin n_fail++; $display("FAIL perf_bubble: got %0d exp 5", Bubble_Cnt); end
    n_chk++;
    if (Stall_Cnt !== 32'd6) begin n_fail++; $display("FAIL perf_stall: got %0d exp 6", Stall_Cnt); end
    Stall = 1'b1; Flush = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    n_chk++;
    if (Bubble_Cnt !== 32'd0 || Stall_Cnt !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset_mid: got %0d/%0d exp 0/0", Bubble_Cnt, Stall_Cnt);
    end
    Reset = 1'b0; Stall = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_single_lane();
`ifdef ID_EX_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID→EX pipeline register, the generalised successor of the fixed-format ID/EX latch.
- Carries IR, PC+4, NUM_LANES operand lanes and FLAG_W sideband flags from decode to execute, plus an explicit valid bit.
- Supports stall (hold) and flush (bubble) with defined priority.
- Tracks consecutive stall cycles and raises a timeout flag for hazard-unit deadlock detection.

Parameters:
- DATA_W, 32, width of IR, PC+4 and each operand lane.
- NUM_LANES, 3, number of operand lanes (lane0=RS, lane1=RT, lane2=EXT by convention).
- FLAG_W, 1, width of sideband flag vector (e.g. bge).
- PC_RESET, 32'h00003000, reset and initial value of PC4_E.
- NOP_IR, 0, instruction word inserted on reset/flush.
- STALL_LIMIT, 16, consecutive stall cycles that assert Stall_Timeout (1..255).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous active-high reset.
- Stall  input  1  hold all stage contents this cycle.
- Flush  input  1  insert bubble this cycle.
- Valid_D  input  1  decode-stage instruction valid.
- IR_D  input  DATA_W  decoded instruction word.
- PC4_D  input  DATA_W  PC+4 from decode.
- Lanes_D  input  NUM_LANES*DATA_W  packed operand lanes; lane i at [i*DATA_W +: DATA_W].
- Flags_D  input  FLAG_W  sideband flags.
- Valid_E  output  1  execute-stage valid.
- IR_E  output  DATA_W  registered instruction.
- PC4_E  output  DATA_W  registered PC+4.
- Lanes_E  output  NUM_LANES*DATA_W  registered lanes, same packing.
- Flags_E  output  FLAG_W  registered flags.
- Stall_Run  output  8  consecutive stall cycle count.
- Stall_Timeout  output  1  Stall_Run >= STALL_LIMIT.

Behaviour:
- All outputs come directly from registers; one-cycle latency from the _D inputs to the _E outputs. No combinational input→output path.
- Priority per posedge Clk: Reset > Flush > Stall > load.
- Reset:
  - IR_E=NOP_IR, PC4_E=PC_RESET, Lanes_E=0, Flags_E=0, Valid_E=0, Stall_Run=0, Stall_Timeout=0.
  - Simulation initial values are identical to the reset values.
- Flush (Reset=0):
  - IR_E=NOP_IR, Valid_E=0, Lanes_E=0, Flags_E=0.
  - PC4_E loads PC4_D, so the bubble keeps its PC for debug.
  - Stall is ignored when Flush=1 in the same cycle.
- Stall (Reset=0, Flush=0): every data register holds its value, Valid_E included.
- Load (Reset=0, Flush=0, Stall=0): every register loads its _D input; Valid_E<=Valid_D.
- Stall_Run:
  - Increments on every Stall=1 cycle that is not overridden by Flush or Reset.
  - Saturates at 255 (no wrap).
  - Clears to 0 on any load or flush cycle.
- Stall_Timeout is registered and equals (next Stall_Run >= STALL_LIMIT). It asserts in the same cycle Stall_Run reaches STALL_LIMIT and stays high while the stall continues. It clears together with Stall_Run.
- Reset mid-stall or mid-flush: the reset values win on that edge; no partial state is kept.
- Lane count and width are fully parametric. With NUM_LANES=1 and FLAG_W=1, the block must still elaborate and behave as above.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - Bubble_Cnt (32): counts flush cycles.
  - Stall_Cnt (32): counts stall cycles not overridden by flush.
- Both counters wrap modulo 2^32 and clear on Reset.
- When undefined, the ports and logic are absent and the rest of the behaviour is unchanged.

Test Plan:
- Reset=1 for 2 cycles, then release -> IR_E=0, PC4_E=0x00003000, Lanes_E=0, Valid_E=0, Stall_Run=0.
- Load IR_D=0x8C220004, PC4_D=0x3004, lanes {0x11,0x22,0x4}, Valid_D=1 -> exactly one edge later the _E outputs show these values with Valid_E=1.
- Stall=1 for 3 cycles while the _D inputs change every cycle -> _E outputs stay frozen and Stall_Run steps 1,2,3. Releasing Stall loads the current _D inputs and clears Stall_Run to 0.
- Flush=1 together with Stall=1, PC4_D=0x3010 -> IR_E=0, Valid_E=0, Lanes_E=0, Flags_E=0, PC4_E=0x3010, Stall_Run=0.
- STALL_LIMIT=4, hold Stall 300 cycles -> Stall_Timeout rises on the 4th stall edge, Stall_Run saturates at 255, and both clear on the first load.
- With ID_EX_PERF_CNT_EN defined: 5 flushes and 7 stalls, one of the stall cycles also flushed -> Bubble_Cnt=5 and Stall_Cnt=6. Reset mid-sequence returns both to 0.
